// File: rtl/morse_pkg.sv
// Shared constants and code-word classification for the Morse-to-ASCII mapper.
// Code words are heap indices: a leading 1 followed by the symbols MSB-first (dot=0, dash=1).
package morse_pkg;

  localparam logic [7:0] ASCII_NUL        = 8'h00;
  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_UPPER_BASE = 8'h41;
  localparam logic [7:0] ASCII_LOWER_BASE = 8'h61;

  localparam int unsigned CODE_IDX_W = 6;

  localparam logic [5:0] CODE_A = 6'h05;
  localparam logic [5:0] CODE_B = 6'h18;
  localparam logic [5:0] CODE_C = 6'h1A;
  localparam logic [5:0] CODE_D = 6'h0C;
  localparam logic [5:0] CODE_E = 6'h02;
  localparam logic [5:0] CODE_F = 6'h12;
  localparam logic [5:0] CODE_G = 6'h0E;
  localparam logic [5:0] CODE_H = 6'h10;
  localparam logic [5:0] CODE_I = 6'h04;
  localparam logic [5:0] CODE_J = 6'h17;
  localparam logic [5:0] CODE_K = 6'h0D;
  localparam logic [5:0] CODE_L = 6'h14;
  localparam logic [5:0] CODE_M = 6'h07;
  localparam logic [5:0] CODE_N = 6'h06;
  localparam logic [5:0] CODE_O = 6'h0F;
  localparam logic [5:0] CODE_P = 6'h16;
  localparam logic [5:0] CODE_Q = 6'h1D;
  localparam logic [5:0] CODE_R = 6'h0A;
  localparam logic [5:0] CODE_S = 6'h08;
  localparam logic [5:0] CODE_T = 6'h03;
  localparam logic [5:0] CODE_U = 6'h09;
  localparam logic [5:0] CODE_V = 6'h11;
  localparam logic [5:0] CODE_W = 6'h0B;
  localparam logic [5:0] CODE_X = 6'h19;
  localparam logic [5:0] CODE_Y = 6'h1B;
  localparam logic [5:0] CODE_Z = 6'h1C;

  localparam logic [5:0] CODE_0 = 6'h3F;
  localparam logic [5:0] CODE_1 = 6'h2F;
  localparam logic [5:0] CODE_2 = 6'h27;
  localparam logic [5:0] CODE_3 = 6'h23;
  localparam logic [5:0] CODE_4 = 6'h21;
  localparam logic [5:0] CODE_5 = 6'h20;
  localparam logic [5:0] CODE_6 = 6'h30;
  localparam logic [5:0] CODE_7 = 6'h38;
  localparam logic [5:0] CODE_8 = 6'h3C;
  localparam logic [5:0] CODE_9 = 6'h3E;

  typedef enum logic [1:0] {
    SYM_NONE   = 2'd0,
    SYM_LETTER = 2'd1,
    SYM_DIGIT  = 2'd2
  } sym_kind_e;

  typedef struct packed {
    sym_kind_e  kind;
    logic [4:0] idx;
  } sym_t;

  // idx is the offset from 'A' or '0'; SYM_NONE means the code is unmapped
  function automatic sym_t classify_code(input logic [5:0] code);
    sym_t s;
    case (code)
      CODE_A:  s = '{SYM_LETTER, 5'd0};
      CODE_B:  s = '{SYM_LETTER, 5'd1};
      CODE_C:  s = '{SYM_LETTER, 5'd2};
      CODE_D:  s = '{SYM_LETTER, 5'd3};
      CODE_E:  s = '{SYM_LETTER, 5'd4};
      CODE_F:  s = '{SYM_LETTER, 5'd5};
      CODE_G:  s = '{SYM_LETTER, 5'd6};
      CODE_H:  s = '{SYM_LETTER, 5'd7};
      CODE_I:  s = '{SYM_LETTER, 5'd8};
      CODE_J:  s = '{SYM_LETTER, 5'd9};
      CODE_K:  s = '{SYM_LETTER, 5'd10};
      CODE_L:  s = '{SYM_LETTER, 5'd11};
      CODE_M:  s = '{SYM_LETTER, 5'd12};
      CODE_N:  s = '{SYM_LETTER, 5'd13};
      CODE_O:  s = '{SYM_LETTER, 5'd14};
      CODE_P:  s = '{SYM_LETTER, 5'd15};
      CODE_Q:  s = '{SYM_LETTER, 5'd16};
      CODE_R:  s = '{SYM_LETTER, 5'd17};
      CODE_S:  s = '{SYM_LETTER, 5'd18};
      CODE_T:  s = '{SYM_LETTER, 5'd19};
      CODE_U:  s = '{SYM_LETTER, 5'd20};
      CODE_V:  s = '{SYM_LETTER, 5'd21};
      CODE_W:  s = '{SYM_LETTER, 5'd22};
      CODE_X:  s = '{SYM_LETTER, 5'd23};
      CODE_Y:  s = '{SYM_LETTER, 5'd24};
      CODE_Z:  s = '{SYM_LETTER, 5'd25};
      CODE_0:  s = '{SYM_DIGIT, 5'd0};
      CODE_1:  s = '{SYM_DIGIT, 5'd1};
      CODE_2:  s = '{SYM_DIGIT, 5'd2};
      CODE_3:  s = '{SYM_DIGIT, 5'd3};
      CODE_4:  s = '{SYM_DIGIT, 5'd4};
      CODE_5:  s = '{SYM_DIGIT, 5'd5};
      CODE_6:  s = '{SYM_DIGIT, 5'd6};
      CODE_7:  s = '{SYM_DIGIT, 5'd7};
      CODE_8:  s = '{SYM_DIGIT, 5'd8};
      CODE_9:  s = '{SYM_DIGIT, 5'd9};
      default: s = '{SYM_NONE, 5'd0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational code-word decode: maps a heap-index Morse code to its ASCII
// character, or to ERR_CHAR with o_err set when the code is unmapped.
module morse_lut #(
  parameter int         CODE_W     = 8,
  parameter logic [7:0] ERR_CHAR   = 8'h3F,
  parameter bit         LOWER_CASE = 1'b0
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [7:0]        o_char,
  output logic              o_err
);
  import morse_pkg::*;

  logic [15:0] w_code_ext;
  logic        w_hi_nz;
  sym_t        w_sym;
  logic [7:0]  w_letter_base;

  // Bits above the 6-bit table index only decide mapped vs. unmapped
  assign w_code_ext    = 16'(i_code);
  assign w_hi_nz       = |w_code_ext[15:CODE_IDX_W];
  assign w_sym         = classify_code(w_code_ext[CODE_IDX_W-1:0]);
  assign w_letter_base = LOWER_CASE ? ASCII_LOWER_BASE : ASCII_UPPER_BASE;

  always_comb begin
    o_char = ERR_CHAR;
    o_err  = 1'b1;
    if (w_hi_nz) begin
      o_char = ERR_CHAR;
      o_err  = 1'b1;
    end else begin
      case (w_sym.kind)
        SYM_LETTER: begin
          o_char = w_letter_base + {3'b000, w_sym.idx};
          o_err  = 1'b0;
        end
        SYM_DIGIT: begin
          o_char = ASCII_DIGIT_BASE + {3'b000, w_sym.idx};
          o_err  = 1'b0;
        end
        default: begin
          o_char = ERR_CHAR;
          o_err  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/morse_ascii_mapper.sv
// Morse code-word to ASCII mapper with word-space insertion and an output FIFO.
// All outputs are registered; the FIFO head is presented on ascii when out_valid is high.
module morse_ascii_mapper #(
  parameter int         CODE_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ERR_CHAR   = 8'h3F,
  parameter bit         LOWER_CASE = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sym_valid,
  input  logic [CODE_W-1:0]             sym_code,
  input  logic                          ws,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    ascii,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_pulse,
  output logic                          overflow
);
  import morse_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [7:0]    r_ascii;
  logic          r_err_pulse;
  logic          r_overflow;
  logic          r_space_pend;
  logic          r_have_last;
  logic          r_last_space;

  logic [7:0]    w_lut_char;
  logic          w_lut_err;
  logic          w_pop;
  logic          w_full;
  logic          w_space_ok;
  logic          w_wr_req;
  logic [7:0]    w_wr_char;
  logic          w_wr_err;
  logic          w_pend_nxt;
  logic          w_wr_acc;
  logic          w_drop;
  logic [CW-1:0] w_count_after_pop;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_rd_nxt;
  logic [7:0]    w_head_nxt;

  morse_lut #(
    .CODE_W     (CODE_W),
    .ERR_CHAR   (ERR_CHAR),
    .LOWER_CASE (LOWER_CASE)
  ) u_lut (
    .i_code (sym_code),
    .o_char (w_lut_char),
    .o_err  (w_lut_err)
  );

  assign w_pop      = r_out_valid && out_ready;
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_space_ok = r_have_last && !r_last_space;

  // Write selection: a symbol always wins; a space (new or pending) goes out on a symbol-free cycle
  always_comb begin
    w_wr_req   = 1'b0;
    w_wr_char  = ASCII_NUL;
    w_wr_err   = 1'b0;
    w_pend_nxt = r_space_pend;
    if (sym_valid) begin
      w_wr_req   = 1'b1;
      w_wr_char  = w_lut_char;
      w_wr_err   = w_lut_err;
      w_pend_nxt = r_space_pend || ws;
    end else if (ws || r_space_pend) begin
      w_wr_req   = w_space_ok;
      w_wr_char  = ASCII_SPACE;
      w_wr_err   = 1'b0;
      w_pend_nxt = 1'b0;
    end else begin
      w_wr_req   = 1'b0;
      w_wr_char  = ASCII_NUL;
      w_wr_err   = 1'b0;
      w_pend_nxt = r_space_pend;
    end
  end

  assign w_wr_acc          = w_wr_req && (!w_full || w_pop);
  assign w_drop            = w_wr_req && w_full && !w_pop;
  assign w_count_after_pop = r_count - CW'(w_pop);
  assign w_count_nxt       = w_count_after_pop + CW'(w_wr_acc);
  assign w_rd_nxt          = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  // Next head: the incoming character lands directly at the head when nothing else remains queued
  always_comb begin
    w_head_nxt = ASCII_NUL;
    if (w_count_nxt == CW'(0)) begin
      w_head_nxt = ASCII_NUL;
    end else if (w_wr_acc && (w_count_after_pop == CW'(0))) begin
      w_head_nxt = w_wr_char;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wr_ptr] <= w_wr_char;
    end
  end

  // Pointers, occupancy, status flags and the space-tracking state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_ascii      <= ASCII_NUL;
      r_err_pulse  <= 1'b0;
      r_overflow   <= 1'b0;
      r_space_pend <= 1'b0;
      r_have_last  <= 1'b0;
      r_last_space <= 1'b0;
    end else begin
      r_rd_ptr     <= w_rd_nxt;
      r_wr_ptr     <= w_wr_acc ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
      r_count      <= w_count_nxt;
      r_out_valid  <= (w_count_nxt != CW'(0));
      r_ascii      <= w_head_nxt;
      r_err_pulse  <= w_wr_err;
      r_overflow   <= r_overflow || w_drop;
      r_space_pend <= w_pend_nxt;
      // Dropped writes still count as "last written" so spacing follows the intended text
      if (w_wr_req) begin
        r_have_last  <= 1'b1;
        r_last_space <= (w_wr_char == ASCII_SPACE);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign ascii      = r_ascii;
  assign fifo_count = r_count;
  assign err_pulse  = r_err_pulse;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_morse_ascii_mapper.sv
// Scoreboard bench for morse_ascii_mapper: a driver feeds directed and random stimulus
// through a reference model; a monitor pops expected characters on every handshake.
module tb_morse_ascii_mapper;

  localparam int CODE_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              sym_valid;
  logic [CODE_W-1:0] sym_code;
  logic              ws;
  logic              out_ready;
  logic              out_valid,    lc_out_valid;
  logic [7:0]        ascii,        lc_ascii;
  logic [CNT_W-1:0]  fifo_count,   lc_fifo_count;
  logic              err_pulse,    lc_err_pulse;
  logic              overflow,     lc_overflow;

  morse_ascii_mapper #(.CODE_W(CODE_W), .FIFO_DEPTH(DEPTH), .ERR_CHAR(8'h3F), .LOWER_CASE(1'b0)) dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_code(sym_code), .ws(ws),
    .out_valid(out_valid), .out_ready(out_ready), .ascii(ascii), .fifo_count(fifo_count),
    .err_pulse(err_pulse), .overflow(overflow));

  morse_ascii_mapper #(.CODE_W(CODE_W), .FIFO_DEPTH(DEPTH), .ERR_CHAR(8'h3F), .LOWER_CASE(1'b1)) dut_lc (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_code(sym_code), .ws(ws),
    .out_valid(lc_out_valid), .out_ready(out_ready), .ascii(lc_ascii), .fifo_count(lc_fifo_count),
    .err_pulse(lc_err_pulse), .overflow(lc_overflow));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  int         m_count;
  bit         m_ovf, m_err, m_pend, m_have_last;
  logic [7:0] m_last;
  logic [7:0] mon_e;

  logic [7:0] letter_codes [26] = '{8'h05, 8'h18, 8'h1A, 8'h0C, 8'h02, 8'h12, 8'h0E, 8'h10, 8'h04,
                                    8'h17, 8'h0D, 8'h14, 8'h07, 8'h06, 8'h0F, 8'h16, 8'h1D, 8'h0A,
                                    8'h08, 8'h03, 8'h09, 8'h11, 8'h0B, 8'h19, 8'h1B, 8'h1C};
  logic [7:0] digit_codes [10]  = '{8'h3F, 8'h2F, 8'h27, 8'h23, 8'h21, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3E};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: {err, char} from the letter/digit tables
  function automatic logic [8:0] ref_decode(input logic [CODE_W-1:0] c);
    if (c >= 64) return {1'b1, 8'h3F};
    for (int i = 0; i < 26; i++) if (c == letter_codes[i]) return {1'b0, 8'(8'h41 + i)};
    for (int i = 0; i < 10; i++) if (c == digit_codes[i]) return {1'b0, 8'(8'h30 + i)};
    return {1'b1, 8'h3F};
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? 8'(c + 8'h20) : c;
  endfunction

  task automatic attempt(input logic [7:0] ch, input bit pop);
    m_have_last = 1'b1;
    m_last      = ch;
    if (m_count < DEPTH || pop) begin
      exp_q.push_back(ch);
      m_count++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit rst, input bit sv, input logic [CODE_W-1:0] code,
                      input bit w, input bit rdy);
    bit         pop;
    logic [8:0] d;
    reset = rst; sym_valid = sv; sym_code = code; ws = w; out_ready = rdy;
    if (rst) begin
      m_count = 0; exp_q.delete(); m_ovf = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_have_last = 1'b0;
    end else begin
      pop   = (m_count > 0) && rdy;
      d     = ref_decode(code);
      m_err = sv && d[8];
      if (sv) begin
        attempt(d[7:0], pop);
        if (w) m_pend = 1'b1;
      end else if (w || m_pend) begin
        m_pend = 1'b0;
        if (m_have_last && m_last != 8'h20) attempt(8'h20, pop);
      end
      if (pop) m_count--;
    end
    @(posedge clk);
    #2;
    check("fifo_count", int'(fifo_count), m_count);
    check("out_valid", int'(out_valid), int'(m_count != 0));
    check("overflow", int'(overflow), int'(m_ovf));
    check("err_pulse", int'(err_pulse), int'(m_err));
    check("lc_status", int'({lc_fifo_count, lc_overflow, lc_err_pulse, lc_out_valid}),
          int'({CNT_W'(m_count), m_ovf, m_err, m_count != 0}));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, rdy);
  endtask

  // Monitor: compare the head against the scoreboard on every accepted pop
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h, expected no output at %0t", ascii, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("ascii", int'(ascii), int'(mon_e));
          check("ascii_lc", int'(lc_ascii), int'(to_lower(mon_e)));
        end
      end else if (out_valid === 1'b0) begin
        check("ascii_idle", int'(ascii), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver: directed scenarios followed by randomized traffic
  initial begin
    int         r;
    logic [7:0] c;
    reset = 1'b1; sym_valid = 1'b0; sym_code = '0; ws = 1'b0; out_ready = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h05, 1'b1, 1'b0);

    step(1'b0, 1'b1, 8'h05, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h18, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h2F, 1'b0, 1'b1);
    idle(2, 1'b1);

    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    idle(1, 1'b1);
    step(1'b0, 1'b1, 8'h45, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    idle(2, 1'b1);

    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);
    step(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);

    step(1'b0, 1'b1, 8'h03, 1'b1, 1'b1);
    idle(3, 1'b1);

    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, letter_codes[i], 1'b0, 1'b0);
    step(1'b0, 1'b1, letter_codes[5], 1'b0, 1'b1);
    idle(6, 1'b1);

    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, digit_codes[i], 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
    idle(1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       c = letter_codes[$urandom_range(0, 25)];
        1:       c = digit_codes[$urandom_range(0, 9)];
        2:       c = 8'($urandom_range(0, 63));
        default: c = 8'($urandom);
      endcase
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1)), 1'b0);
      else
        step(1'b0, 1'($urandom_range(0, 1)), c, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end
    idle(DEPTH + 4, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_ascii_mapper.md
MORSE_ASCII_MAPPER -- requirements
Module: morse_ascii_mapper

Interface
REQ-001 The block SHALL have parameter CODE_W, default 8, giving the Morse code-word width (legal range 6..16).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving output FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have parameter ERR_CHAR, default 8'h3F, the character emitted for an unmapped code.
REQ-004 The block SHALL have parameter LOWER_CASE, default 0; when 1, letters map to 8'h61..8'h7A.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock (all logic on rising edge).
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port sym_valid, input, 1 bit, one-cycle strobe marking sym_code valid.
REQ-008 The block SHALL have port sym_code, input, CODE_W bits: heap-index code word, with leading 1 then symbols MSB-first (dot=0, dash=1).
REQ-009 The block SHALL have port ws, input, 1 bit, one-cycle word-space request.
REQ-010 The block SHALL have port out_valid, output, 1 bit, FIFO head valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, consumer accept.
REQ-012 The block SHALL have port ascii, output, 8 bits, FIFO head character (8'h00 when out_valid=0).
REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, current occupancy.
REQ-014 The block SHALL have port err_pulse, output, 1 bit, one-cycle flag for each unmapped code written.
REQ-015 The block SHALL have port overflow, output, 1 bit, sticky flag for any dropped write.

Function
REQ-016 Letter codes SHALL map as before: 0x05->A, 0x18->B, 0x1A->C, 0x0C->D, 0x02->E, 0x12->F, 0x0E->G, 0x10->H, 0x04->I, 0x17->J, 0x0D->K, 0x14->L, 0x07->M, 0x06->N, 0x0F->O, 0x16->P, 0x1D->Q, 0x0A->R, 0x08->S, 0x03->T, 0x09->U, 0x11->V, 0x0B->W, 0x19->X, 0x1B->Y, 0x1C->Z.
REQ-017 Digit codes SHALL map: 0x3F->'0', 0x2F->'1', 0x27->'2', 0x23->'3', 0x21->'4', 0x20->'5', 0x30->'6', 0x38->'7', 0x3C->'8', 0x3E->'9'.
REQ-018 Any other code (including 0, 1, and any value >= 0x40) SHALL write ERR_CHAR and assert err_pulse in the write cycle.
REQ-019 A sym_valid in cycle N SHALL write the FIFO at edge N, giving out_valid=1 with that character from cycle N+1 when the FIFO was empty.
REQ-020 A ws pulse SHALL write 8'h20 unless the last character written since reset was 8'h20 or nothing has been written since reset; a suppressed space is not an error.
REQ-021 When sym_valid and ws coincide, the character SHALL be written that cycle and the space SHALL be held in a one-entry pending flag and written in the next cycle that has no sym_valid.
REQ-022 A further ws while the space is pending SHALL merge with it, and sym_valid SHALL always take write priority over the pending space.
REQ-023 A pop SHALL occur when out_valid and out_ready are both 1, advancing the head on that edge.
REQ-024 A write when full SHALL be accepted if a pop occurs in the same cycle; otherwise it SHALL be dropped and overflow set.
REQ-025 A dropped letter SHALL still update the last-written tracker (REQ-020), and a dropped space SHALL be discarded, not retried.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and fifo_count SHALL reach FIFO_DEPTH exactly when full.
REQ-027 Bits of sym_code above bit 5 SHALL only qualify as zero/non-zero for the error decision (REQ-018).

Reset
REQ-028 On reset=1 at a rising edge, the block SHALL clear FIFO pointers, fifo_count, out_valid, ascii, err_pulse, overflow, the pending space and the last-written tracker, regardless of activity in flight.
REQ-029 sym_valid and ws SHALL be ignored in any cycle where reset=1.

Structure
REQ-030 A shared package morse_pkg SHALL hold the ASCII constants (space, letter/digit bases) and the code-word localparams.
REQ-031 The decode SHALL be a combinational sub-module morse_lut (code in, char and err out); the FIFO and control SHALL live in morse_ascii_mapper.

Verification
REQ-032 Sequence 0x05, 0x18, 0x2F, each with out_ready=1 -> outputs 0x41, 0x42, 0x31, each valid one cycle after its strobe.
REQ-033 sym_code=0x01 -> ascii=0x3F with err_pulse high for one cycle; repeat with LOWER_CASE=1 and 0x05 -> 0x61.
REQ-034 ws right after reset -> no write; 0x02 then ws, ws -> output 0x45, 0x20 only.
REQ-035 sym_valid(0x03) and ws in the same cycle -> 0x54 then 0x20 on consecutive write cycles.
REQ-036 out_ready=0 with 5 writes at FIFO_DEPTH=4 -> fifo_count=4, overflow=1, first four characters drained in order; a write coinciding with a pop when full is accepted.
REQ-037 Reset asserted with 3 entries queued -> next cycle out_valid=0, fifo_count=0, overflow=0.
